// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite definitions for the initiator-side interconnect blocks.
package ahb_lite_pkg;

    // Address width carried through the hold registers; initiators narrower
    // than this are zero-extended on capture and truncated on replay.
    localparam int AHB_ADDR_WIDTH = 32;

    localparam logic [1:0] AHB_XFER_IDLE   = 2'b00;
    localparam logic [1:0] AHB_XFER_BUSY   = 2'b01;
    localparam logic [1:0] AHB_XFER_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_XFER_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        ISSUED = 2'd2
    } init_state_e;

    typedef struct packed {
        logic [AHB_ADDR_WIDTH-1:0] addr;
        logic                      write;
        logic [1:0]                trans;
        logic [2:0]                size;
    } ahb_addr_phase_t;

    // True for transfer types that open a data phase
    function automatic logic is_xfer(input logic [1:0] trans);
        return (trans == AHB_XFER_NONSEQ) || (trans == AHB_XFER_SEQ);
    endfunction

endpackage

// File: rtl/ahb_lite_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, searching from
// the index after the last winner; the pointer only moves when advance is set.
module ahb_lite_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               hclk,
    input  logic               hreset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] last_q;
    logic [IW-1:0] win_idx;
    logic          found;

    // Scan requesters in rotating order starting just after the last winner
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (j == ((int'(last_q) + k) % NUM_REQ))) begin
                    grant[j] = 1'b1;
                    win_idx  = IW'(j);
                    found    = 1'b1;
                end
            end
        end
    end

    // Remember the winner so the next search starts after it; reset favours index 0
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            last_q <= IW'(NUM_REQ - 1);
        end else if (advance && found) begin
            last_q <= win_idx;
        end
    end

endmodule

// File: rtl/ahb_lite_initiator_arbiter.sv
// Shares one downstream AHB-Lite initiator port between several upstream
// initiators. A request that loses arbitration is captured in a one-entry
// hold register and the initiator is stalled in its data phase until the
// captured address phase has been replayed downstream.
module ahb_lite_initiator_arbiter
    import ahb_lite_pkg::*;
#(
    parameter int AHB_LITE_ADDR_WIDTH = 32,
    parameter int AHB_LITE_DATA_WIDTH = 32,
    parameter int NUM_INITIATORS      = 2
) (
    input  logic                                                hclk,
    input  logic                                                hreset_n,
    input  logic [NUM_INITIATORS-1:0][AHB_LITE_ADDR_WIDTH-1:0]  haddr_i,
    input  logic [NUM_INITIATORS-1:0][AHB_LITE_DATA_WIDTH-1:0]  hwdata_i,
    input  logic [NUM_INITIATORS-1:0]                           hwrite_i,
    input  logic [NUM_INITIATORS-1:0][1:0]                      htrans_i,
    input  logic [NUM_INITIATORS-1:0][2:0]                      hsize_i,
    output logic [NUM_INITIATORS-1:0]                           hready_o,
    output logic [NUM_INITIATORS-1:0]                           hresp_o,
    output logic [NUM_INITIATORS-1:0][AHB_LITE_DATA_WIDTH-1:0]  hrdata_o,
    output logic [AHB_LITE_ADDR_WIDTH-1:0]                      haddr_o,
    output logic [AHB_LITE_DATA_WIDTH-1:0]                      hwdata_o,
    output logic                                                hwrite_o,
    output logic [1:0]                                          htrans_o,
    output logic [2:0]                                          hsize_o,
    input  logic                                                hready_i,
    input  logic                                                hresp_i,
    input  logic [AHB_LITE_DATA_WIDTH-1:0]                      hrdata_i,
    output logic [NUM_INITIATORS-1:0]                           grant_o
);
    init_state_e     state_q    [NUM_INITIATORS];
    ahb_addr_phase_t hold_q     [NUM_INITIATORS];
    ahb_addr_phase_t live_phase [NUM_INITIATORS];
    ahb_addr_phase_t sel_phase;

    logic [NUM_INITIATORS-1:0] live_req;
    logic [NUM_INITIATORS-1:0] req;
    logic [NUM_INITIATORS-1:0] lock_hold;
    logic [NUM_INITIATORS-1:0] issued_vec;
    logic [NUM_INITIATORS-1:0] held_vec;
    logic [NUM_INITIATORS-1:0] arb_grant;
    logic [NUM_INITIATORS-1:0] grant;
    logic [NUM_INITIATORS-1:0] grant_q;
    logic                      locked;
    logic                      advance;

    // Per-initiator handshake back upstream, plus what each one is asking for
    always_comb begin
        for (int i = 0; i < NUM_INITIATORS; i++) begin
            live_phase[i].addr  = AHB_ADDR_WIDTH'(haddr_i[i]);
            live_phase[i].write = hwrite_i[i];
            live_phase[i].trans = htrans_i[i];
            live_phase[i].size  = hsize_i[i];
            issued_vec[i]       = (state_q[i] == ISSUED);
            held_vec[i]         = (state_q[i] == HELD);
            hready_o[i]         = 1'b1;
            hresp_o[i]          = 1'b0;
            hrdata_o[i]         = '0;
            if (issued_vec[i]) begin
                hready_o[i] = hready_i;
                hresp_o[i]  = hresp_i;
                hrdata_o[i] = hrdata_i;
            end else if (held_vec[i]) begin
                hready_o[i] = 1'b0;
            end
            live_req[i]  = is_xfer(htrans_i[i]) &&
                           ((state_q[i] == IDLE) || (issued_vec[i] && hready_i));
            req[i]       = held_vec[i] || live_req[i];
            lock_hold[i] = (htrans_i[i] == AHB_XFER_SEQ) || (htrans_i[i] == AHB_XFER_BUSY);
        end
    end

    // The last accepted owner keeps the bus while it continues a burst
    assign locked  = |(grant_q & lock_hold);
    assign advance = hready_i && !locked;

    ahb_lite_rr_arbiter #(
        .NUM_REQ (NUM_INITIATORS)
    ) u_rr_arbiter (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .req      (req),
        .advance  (advance),
        .grant    (arb_grant)
    );

    // Final grant: frozen while downstream stalls, locked during bursts, else round-robin
    always_comb begin
        grant = '0;
        if (!hreset_n) begin
            grant = '0;
        end else if (!hready_i || locked) begin
            grant = grant_q;
        end else begin
            grant = arb_grant;
        end
    end

    assign grant_o = grant;

    // Address phase comes from the grantee's hold register if it is waiting, else live
    always_comb begin
        sel_phase = '0;
        for (int i = 0; i < NUM_INITIATORS; i++) begin
            if (grant[i]) begin
                sel_phase = held_vec[i] ? hold_q[i] : live_phase[i];
            end
        end
        haddr_o  = AHB_LITE_ADDR_WIDTH'(sel_phase.addr);
        hwrite_o = sel_phase.write;
        htrans_o = sel_phase.trans;
        hsize_o  = sel_phase.size;
    end

    // Write data follows whichever initiator currently owns the data phase
    always_comb begin
        hwdata_o = '0;
        for (int i = 0; i < NUM_INITIATORS; i++) begin
            if (issued_vec[i]) begin
                hwdata_o = hwdata_i[i];
            end
        end
    end

    // Per-initiator IDLE/HELD/ISSUED sequencing and hold-register capture
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            for (int i = 0; i < NUM_INITIATORS; i++) begin
                state_q[i] <= IDLE;
                hold_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INITIATORS; i++) begin
                if (state_q[i] == HELD) begin
                    if (grant[i] && hready_i) begin
                        state_q[i] <= ISSUED;
                    end
                end else if ((state_q[i] == IDLE) || hready_i) begin
                    if (live_req[i] && grant[i] && hready_i) begin
                        state_q[i] <= ISSUED;
                    end else if (live_req[i]) begin
                        state_q[i] <= HELD;
                        hold_q[i]  <= live_phase[i];
                    end else begin
                        state_q[i] <= IDLE;
                    end
                end
            end
        end
    end

    // Remember the owner of the last accepted address phase for locking and stalls
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            grant_q <= '0;
        end else if (hready_i) begin
            grant_q <= grant;
        end
    end

    a_grant_onehot0 : assert property (@(posedge hclk) disable iff (!hreset_n)
        $onehot0(grant));

    a_single_owner : assert property (@(posedge hclk) disable iff (!hreset_n)
        $onehot0(issued_vec));

    for (genvar g = 0; g < NUM_INITIATORS; g++) begin : g_hold_chk
        a_hold_stable : assert property (@(posedge hclk) disable iff (!hreset_n)
            held_vec[g] |=> $stable(hold_q[g]));
    end

endmodule

// File: doc/ahb_lite_initiator_arbiter.md
Name: ahb_lite_initiator_arbiter

Overview:
- Shares one AHB-Lite initiator port (the address decoder's initiator-side port) between NUM_INITIATORS upstream initiators, e.g. the core's data bus and a DMA.
- Round-robin arbitration at transfer boundaries.
- Per-initiator one-entry address-phase hold buffer, so a losing initiator is stalled through its data phase rather than dropped.
- Routes hwdata downstream and hrdata/hresp back according to the data-phase owner.

Parameters:
- AHB_LITE_ADDR_WIDTH, 32, address width.
- AHB_LITE_DATA_WIDTH, 32, data width.
- NUM_INITIATORS, 2, number of upstream initiators; range 2..8.

Ports:
- hclk  in  1  clock
- hreset_n  in  1  reset; asynchronous, active-low
- haddr_i  in  [N-1:0][AW]  per-initiator address
- hwdata_i  in  [N-1:0][DW]  per-initiator write data (data phase)
- hwrite_i  in  [N-1:0]  per-initiator write
- htrans_i  in  [N-1:0][2]  per-initiator transfer type
- hsize_i  in  [N-1:0][3]  per-initiator size
- hready_o  out  [N-1:0]  per-initiator HREADY
- hresp_o  out  [N-1:0]  per-initiator HRESP
- hrdata_o  out  [N-1:0][DW]  per-initiator read data
- haddr_o  out  AW  downstream address
- hwdata_o  out  DW  downstream write data
- hwrite_o  out  1  downstream write
- htrans_o  out  2  downstream transfer type
- hsize_o  out  3  downstream size
- hready_i  in  1  downstream ready
- hresp_i  in  1  downstream response
- hrdata_i  in  DW  downstream read data
- grant_o  out  [N-1:0]  one-hot current address-phase owner (debug/observation)

Behaviour:
- Reset values:
  - hready_o all 1; hresp_o 0; hrdata_o 0.
  - htrans_o IDLE (2'b00); haddr_o/hsize_o/hwrite_o/hwdata_o 0.
  - grant_o 0; RR pointer favours initiator 0.
  - All per-initiator FSMs in IDLE; data owner invalid.
- Per-initiator FSM:
  - IDLE:
    - htrans_i NONSEQ/SEQ, hready_o=1, granted and downstream accepts (hready_i=1) -> ISSUED.
    - Same request but not granted -> capture addr/write/trans/size into the hold register -> HELD.
  - HELD:
    - hready_o=0.
    - When arbiter selects this initiator and hready_i=1: drive held fields downstream -> ISSUED.
  - ISSUED (data owner):
    - hready_o=hready_i; hresp_o=hresp_i; hrdata_o=hrdata_i.
    - On hready_i=1: completes -> IDLE, or follows IDLE rules for a new live request in the same cycle.
- BUSY: accepted only during a granted burst; passed through, never buffered.
- Arbitration:
  - Evaluated only when hready_i=1.
  - Candidates are initiators in HELD, plus initiators with live NONSEQ/SEQ and hready_o=1.
  - Round-robin starting after the last granted index; HELD initiators take no extra priority.
- Burst lock: owner keeps the grant while its live htrans_i is SEQ or BUSY. Re-arbitration happens on IDLE or NONSEQ.
- Downstream mux:
  - Address-phase fields come from the granted initiator (hold register if HELD, otherwise live).
  - htrans_o=IDLE when no grant.
  - hwdata_o comes from the registered data owner's live hwdata_i. AHB requires it stable through the stall.
- Non-owner, non-HELD initiators see hready_o=1, hresp_o=0, hrdata_o=0.
- Two-cycle ERROR:
  - hresp_i is forwarded unchanged to the data owner in both cycles.
  - The owner's next address (typically IDLE) is honoured normally.
- Latency:
  - Granted live request: zero added cycles (combinational pass-through).
  - Held request: +1 cycle minimum, plus whatever the other owner's remaining transfer takes.
- Simultaneous NONSEQ from all initiators: exactly one passes through; all others go HELD in the same cycle.
- Reset mid-transfer: all FSMs to IDLE, hold registers discarded, outputs to reset values asynchronously.
- Assertions:
  - grant_o is one-hot or zero.
  - At most one ISSUED initiator per data phase.
  - A HELD initiator's hold register is never overwritten.

Decomposition:
- Shared package ahb_lite_pkg: AHB_XFER_IDLE/BUSY/NONSEQ/SEQ constants; init_state_e {IDLE, HELD, ISSUED}; packed struct ahb_addr_phase_t {addr, write, trans, size}.
- Sub-module ahb_lite_rr_arbiter (request vector, advance enable -> one-hot grant, rotating pointer), reusable elsewhere.
- Hold registers and per-initiator FSMs are generated in the top module.

Test Plan:
- Single initiator: init0 NONSEQ read 0x1000_0000, hready_i=1, hrdata_i=0xA5A5_A5A5 -> htrans_o=NONSEQ same cycle; hrdata_o[0]=0xA5A5_A5A5 next cycle; init1 untouched.
- Collision:
  - Stimulus: init0 write 0x10 with data 0x11 and init1 write 0x20 with data 0x22 issue NONSEQ in the same cycle, RR pointer at 0.
  - Required: init0 passes through; init1 HELD with hready_o[1]=0; 0x20 issues downstream next cycle with hwdata_o=0x22; hready_o[1] returns to 1 one cycle later.
- Burst lock: init0 4-beat INCR (NONSEQ, SEQ, SEQ, SEQ) while init1 requests at beat 2 -> init1 granted only after beat 4's address phase; no interleaving.
- Downstream wait states: hready_i=0 for 3 cycles during init0's data phase -> hready_o[0]=0 for exactly those 3 cycles; init1 stays HELD; its held fields are unchanged on haddr_o when issued.
- Error: hresp_i=1 for two cycles (hready_i=0 then 1) on init1's transfer -> hresp_o[1]=1 for both cycles; hresp_o[0]=0 throughout.
- Async reset asserted while init1 is HELD -> all hready_o=1, htrans_o=IDLE immediately; after release, no stale held transfer is issued.
